vm_input_conditioner: RTL and testbench

Front-end stage that feeds the vending-machine controller.
- Synchronises and debounces 3 raw coin buttons and 4 raw drink-select switches.
- Emits at most one single-cycle, one-hot event per press, on two output buses: a 3-bit coin bus and a 7-bit selection bus.
- A release-lockout FSM guarantees one event per press and a single asserted bit across both buses.

---
 rtl/vm_input_conditioner.sv | 121 ++++++++++++
 tb/tb_vm_input_conditioner.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vm_input_conditioner.sv
// Vending-machine front end: 2-flop sync, per-input debounce, and release-lockout FSM emitting one-hot events.
// Optional VM_INPUT_DBG_EN adds an 8-bit wrapping count of emitted events on port evt_count.
module vm_input_conditioner #(
  parameter int unsigned DB_COUNT = 500000,
  parameter int          CNT_W    = 20
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [2:0] btn_raw,
  input  logic [3:0] sw_raw,
  output logic [2:0] coin_pulse,
  output logic [6:0] sel_pulse,
  output logic       busy
`ifdef VM_INPUT_DBG_EN
  ,
  output logic [7:0] evt_count
`endif
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_COUNT - 1);

  typedef enum logic [1:0] {IDLE, EMIT, RELEASE} state_t;

  logic [6:0] raw;
  logic [6:0] s1_reg;
  logic [6:0] s2_reg;
  logic [6:0] stable;
  logic [6:0] req;
  logic [6:0] pick;
  state_t     state_reg;

  assign raw = {sw_raw, btn_raw};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= raw;
      s2_reg <= s1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_db
      logic             stable_reg;
      logic [CNT_W-1:0] cnt_reg;

      // The counter only runs while s2 disagrees with the debounced value, so any glitch restarts it.
      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          stable_reg <= 1'b0;
          cnt_reg    <= '0;
        end else if (s2_reg[gi] != stable_reg) begin
          if (cnt_reg == DB_LAST) begin
            stable_reg <= s2_reg[gi];
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end else begin
          cnt_reg <= '0;
        end
      end

      assign stable[gi] = stable_reg;
    end
  endgenerate

  assign req  = stable;
  // Isolate the lowest set bit: nickel has top priority, drink4 the lowest.
  assign pick = req & (~req + 7'd1);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg  <= IDLE;
      coin_pulse <= '0;
      sel_pulse  <= '0;
      busy       <= 1'b0;
`ifdef VM_INPUT_DBG_EN
      evt_count  <= '0;
`endif
    end else begin
      coin_pulse <= '0;
      sel_pulse  <= '0;
      case (state_reg)
        IDLE: begin
          if (req != '0) begin
            coin_pulse <= pick[2:0];
            sel_pulse  <= {pick[6:3], 3'b000};
            state_reg  <= EMIT;
            busy       <= 1'b1;
`ifdef VM_INPUT_DBG_EN
            evt_count  <= evt_count + 8'd1;
`endif
          end else begin
            busy <= 1'b0;
          end
        end
        EMIT: begin
          state_reg <= RELEASE;
          busy      <= 1'b1;
        end
        RELEASE: begin
          if (req == '0) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            busy <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vm_input_conditioner.sv
// Scoreboard bench for vm_input_conditioner with DB_COUNT=4: stimulus queues expected events, a monitor checks them.
module tb_vm_input_conditioner;

  logic       clk;
  logic       clr;
  logic [2:0] btn_raw;
  logic [3:0] sw_raw;
  logic [2:0] coin_pulse;
  logic [6:0] sel_pulse;
  logic       busy;
`ifdef VM_INPUT_DBG_EN
  logic [7:0] evt_count;
`endif

  vm_input_conditioner #(.DB_COUNT(4), .CNT_W(20)) dut (
    .clk        (clk),
    .clr        (clr),
    .btn_raw    (btn_raw),
    .sw_raw     (sw_raw),
    .coin_pulse (coin_pulse),
    .sel_pulse  (sel_pulse),
    .busy       (busy)
`ifdef VM_INPUT_DBG_EN
    ,
    .evt_count  (evt_count)
`endif
  );

  typedef struct {
    int         cyc;
    logic [9:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   ntest = 0;
  int   nfail = 0;

  localparam logic [9:0] NICKEL = 10'd1;
  localparam logic [9:0] DIME   = 10'd2;
  localparam logic [9:0] QUART  = 10'd4;
  localparam logic [9:0] DRINK3 = 10'd32 << 3;
  localparam logic [9:0] DRINK4 = 10'd64 << 3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, cyc=%0d (required completion)", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor: every nonzero output cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!clr && (coin_pulse != '0 || sel_pulse != '0)) begin
      if (exp_q.size() == 0) begin
        ntest++;
        nfail++;
        $display("FAIL unexpected_event: coin=%0d sel=%0d cyc=%0d, required no event", coin_pulse, sel_pulse, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        ntest++;
        if ({sel_pulse, coin_pulse} != e.val) begin
          nfail++;
          $display("FAIL event_value: got coin=%0d sel=%0d, required coin=%0d sel=%0d",
                   coin_pulse, sel_pulse, e.val[2:0], e.val[9:3]);
        end
        ntest++;
        if (cyc != e.cyc) begin
          nfail++;
          $display("FAIL event_cycle: got cyc=%0d, required cyc=%0d", cyc, e.cyc);
        end
        ntest++;
        if (busy !== 1'b1) begin
          nfail++;
          $display("FAIL busy_in_emit: got %0b, required 1", busy);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int req);
    ntest++;
    if (got != req) begin
      nfail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Called right after driving an input change on a negedge.
  task automatic expect_event(input logic [9:0] val);
    exp_t e;
    e.cyc = cyc + 7;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_check(input string name);
    wait_cycles(12);
    check({name, "_busy_idle"}, int'(busy), 0);
    check({name, "_all_events_seen"}, exp_q.size(), 0);
  endtask

  initial begin
    clr     = 1'b1;
    btn_raw = 3'b111;
    sw_raw  = 4'b1111;

    // 1: reset with everything pressed, then one nickel after release of clr
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_coin", int'(coin_pulse), 0);
      check("rst_sel", int'(sel_pulse), 0);
      check("rst_busy", int'(busy), 0);
`ifdef VM_INPUT_DBG_EN
      check("rst_evt_count", int'(evt_count), 0);
`endif
    end
    clr = 1'b0;
    expect_event(NICKEL);
    wait_cycles(20);
    btn_raw = '0;
    sw_raw  = '0;
    idle_check("t1");

    // 2: dime held 20 cycles
    @(negedge clk);
    btn_raw[1] = 1'b1;
    expect_event(DIME);
    wait_cycles(8);
    check("t2_busy_held", int'(busy), 1);
    wait_cycles(12);
    btn_raw[1] = 1'b0;
    wait_cycles(3);
    check("t2_busy_after_release", int'(busy), 1);
    idle_check("t2");

    // 3: 3-cycle glitch is rejected, 5-cycle hold is accepted
    @(negedge clk);
    sw_raw[2] = 1'b1;
    wait_cycles(3);
    sw_raw[2] = 1'b0;
    wait_cycles(12);
    check("t3_glitch_busy", int'(busy), 0);
    sw_raw[2] = 1'b1;
    expect_event(DRINK3);
    wait_cycles(5);
    sw_raw[2] = 1'b0;
    idle_check("t3");

    // 4: quarter and drink1 together: only the quarter
    @(negedge clk);
    btn_raw[2] = 1'b1;
    sw_raw[0]  = 1'b1;
    expect_event(QUART);
    wait_cycles(12);
    btn_raw[2] = 1'b0;
    wait_cycles(6);
    sw_raw[0] = 1'b0;
    idle_check("t4");

    // 5: drink4 pressed during a nickel hold is locked out; a fresh press is accepted
    @(negedge clk);
    btn_raw[0] = 1'b1;
    expect_event(NICKEL);
    wait_cycles(15);
    sw_raw[3] = 1'b1;
    wait_cycles(10);
    btn_raw[0] = 1'b0;
    sw_raw[3]  = 1'b0;
    idle_check("t5a");
    sw_raw[3] = 1'b1;
    expect_event(DRINK4);
    wait_cycles(8);
    sw_raw[3] = 1'b0;
    idle_check("t5b");

    // 6: 257 nickel presses after a fresh reset
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
`ifdef VM_INPUT_DBG_EN
    check("t6_evt_count_rst", int'(evt_count), 0);
`endif
    clr = 1'b0;
    for (int i = 0; i < 257; i++) begin
      @(negedge clk);
      btn_raw[0] = 1'b1;
      expect_event(NICKEL);
      wait_cycles(8);
      btn_raw[0] = 1'b0;
      wait_cycles(10);
    end
    idle_check("t6");
`ifdef VM_INPUT_DBG_EN
    check("t6_evt_count_wrap", int'(evt_count), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
